// File: rtl/irq_sched.sv
// irq_sched: interrupt scheduler between peripheral interrupt sources and the CPU.
//   Latches rising edges of the source lines into PENDING, masks them with ENABLE
//   and presents the lowest-index winner to the CPU. A claim/complete handshake
//   ensures that only one source is serviced at a time. A new edge on a source
//   whose PENDING bit is already set is recorded in the sticky OVERRUN register.
// Ports:
//   clk, rst      single clock, synchronous active-high reset
//   src_irq_i     source irq lines (pulses or levels); src 0 is the sample timer
//   cfg_we_i      config write strobe
//   cfg_addr_i    0=ENABLE 1=PENDING(W1C) 2=CLAIM_ID(RO) 3=OVERRUN(W1C)
//   cfg_wdata_i   config write data
//   cfg_rdata_o   combinational read data for cfg_addr_i
//   claim_i       CPU accepts the presented interrupt
//   complete_i    CPU finished the ISR
//   irq_o         interrupt request to the CPU
//   irq_id_o      ID of the presented/serviced source
module irq_sched #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned ID_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_irq_i,
  input  logic             cfg_we_i,
  input  logic [1:0]       cfg_addr_i,
  input  logic [31:0]      cfg_wdata_i,
  output logic [31:0]      cfg_rdata_o,
  input  logic             claim_i,
  input  logic             complete_i,
  output logic             irq_o,
  output logic [ID_W-1:0]  irq_id_o
);

  localparam logic [1:0] AddrEnable  = 2'd0;
  localparam logic [1:0] AddrPending = 2'd1;
  localparam logic [1:0] AddrClaimId = 2'd2;
  localparam logic [1:0] AddrOverrun = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StAssert,
    StService
  } state_e;

  state_e           r_state, w_state_nxt;
  logic             r_irq, w_irq_nxt;
  logic [ID_W-1:0]  r_id, w_id_nxt;
  logic [N_SRC-1:0] r_prev;
  logic [N_SRC-1:0] r_enable, w_enable_nxt;
  logic [N_SRC-1:0] r_pending, w_pending_nxt;
  logic [N_SRC-1:0] r_overrun, w_overrun_nxt;

  logic [N_SRC-1:0] w_edge;
  logic [N_SRC-1:0] w_masked;
  logic [N_SRC-1:0] w_id_oh;
  logic [N_SRC-1:0] w_pend_clr;
  logic [N_SRC-1:0] w_ovr_clr;
  logic [N_SRC-1:0] w_claim_clr;
  logic [ID_W-1:0]  w_win_id;
  logic             w_claim_take;
  logic             w_withdraw;

  // Upper write-data bits are architecturally ignored.
  logic unused_wdata;
  assign unused_wdata = ^cfg_wdata_i;

  assign w_edge   = src_irq_i & ~r_prev;
  assign w_masked = r_pending & r_enable;
  assign w_id_oh  = N_SRC'(1) << r_id;

  // Software register writes.
  always_comb begin
    w_enable_nxt = r_enable;
    w_pend_clr   = '0;
    w_ovr_clr    = '0;
    if (cfg_we_i) begin
      case (cfg_addr_i)
        AddrEnable:  w_enable_nxt = cfg_wdata_i[N_SRC-1:0];
        AddrPending: w_pend_clr   = cfg_wdata_i[N_SRC-1:0];
        AddrOverrun: w_ovr_clr    = cfg_wdata_i[N_SRC-1:0];
        default:     ;
      endcase
    end
  end

  assign w_claim_take = (r_state == StAssert) && claim_i;
  assign w_claim_clr  = w_claim_take ? w_id_oh : '0;

  // Edges are OR-ed in after the clears so a same-cycle set always wins.
  assign w_pending_nxt = (r_pending & ~w_pend_clr & ~w_claim_clr) | w_edge;
  assign w_overrun_nxt = (r_overrun & ~w_ovr_clr) | (w_edge & r_pending);

  // Withdraw looks at next-state values so the request drops the cycle
  // after software disables or clears the presented source.
  assign w_withdraw = ~|(w_id_oh & w_enable_nxt & w_pending_nxt);

  // Lowest-index winner: scan downwards so the lowest set bit is written last.
  always_comb begin
    w_win_id = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (w_masked[i]) begin
        w_win_id = ID_W'(i);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_irq_nxt   = r_irq;
    w_id_nxt    = r_id;
    case (r_state)
      StIdle: begin
        if (|w_masked) begin
          w_id_nxt    = w_win_id;
          w_irq_nxt   = 1'b1;
          w_state_nxt = StAssert;
        end
      end
      StAssert: begin
        if (claim_i) begin
          w_irq_nxt   = 1'b0;
          w_state_nxt = StService;
        end else if (w_withdraw) begin
          w_irq_nxt   = 1'b0;
          w_state_nxt = StIdle;
        end
      end
      StService: begin
        w_irq_nxt = 1'b0;
        if (complete_i) begin
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_irq_nxt   = 1'b0;
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_irq     <= 1'b0;
      r_id      <= '0;
      r_prev    <= '0;
      r_enable  <= '0;
      r_pending <= '0;
      r_overrun <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_irq     <= w_irq_nxt;
      r_id      <= w_id_nxt;
      r_prev    <= src_irq_i;
      r_enable  <= w_enable_nxt;
      r_pending <= w_pending_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  always_comb begin
    cfg_rdata_o = '0;
    case (cfg_addr_i)
      AddrEnable:  cfg_rdata_o[N_SRC-1:0] = r_enable;
      AddrPending: cfg_rdata_o[N_SRC-1:0] = r_pending;
      AddrClaimId: cfg_rdata_o[ID_W-1:0]  = r_id;
      AddrOverrun: cfg_rdata_o[N_SRC-1:0] = r_overrun;
      default:     ;
    endcase
  end

  assign irq_o    = r_irq;
  assign irq_id_o = r_id;

endmodule

// File: tb/tb_irq_sched.sv
module tb_irq_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  src_irq_i;
  logic        cfg_we_i;
  logic [1:0]  cfg_addr_i;
  logic [31:0] cfg_wdata_i;
  logic [31:0] cfg_rdata_o;
  logic        claim_i;
  logic        complete_i;
  logic        irq_o;
  logic [4:0]  irq_id_o;

  int n_checks = 0;
  int n_fail   = 0;

  irq_sched #(
    .N_SRC(4),
    .ID_W (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .src_irq_i  (src_irq_i),
    .cfg_we_i   (cfg_we_i),
    .cfg_addr_i (cfg_addr_i),
    .cfg_wdata_i(cfg_wdata_i),
    .cfg_rdata_o(cfg_rdata_o),
    .claim_i    (claim_i),
    .complete_i (complete_i),
    .irq_o      (irq_o),
    .irq_id_o   (irq_id_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock with the given inputs; pulses are dropped #1 after the edge.
  task automatic drive_cycle(input logic r, input logic [3:0] src, input logic we,
                             input logic [1:0] addr, input logic [31:0] wd,
                             input logic claim, input logic comp);
    rst         = r;
    src_irq_i   = src;
    cfg_we_i    = we;
    cfg_addr_i  = addr;
    cfg_wdata_i = wd;
    claim_i     = claim;
    complete_i  = comp;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    cfg_we_i   = 1'b0;
    claim_i    = 1'b0;
    complete_i = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [1:0] addr, input logic [31:0] exp);
    cfg_addr_i = addr;
    #1;
    check(name, cfg_rdata_o, exp);
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic [3:0]  src;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        claim;
    logic        comp;
    logic [1:0]  rd;
    logic        exp_irq;
    logic [4:0]  exp_id;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] src, input logic we, input logic [1:0] addr,
                              input logic [31:0] wdata, input logic claim, input logic comp,
                              input logic [1:0] rd, input logic exp_irq,
                              input logic [4:0] exp_id, input logic [31:0] exp_rd);
    vec_t v;
    v.src = src; v.we = we; v.addr = addr; v.wdata = wdata; v.claim = claim;
    v.comp = comp; v.rd = rd; v.exp_irq = exp_irq; v.exp_id = exp_id; v.exp_rd = exp_rd;
    return v;
  endfunction

  // ---------------- behavioural reference model ----------------
  localparam int ModeIdle = 0, ModePresent = 1, ModeService = 2;
  bit [3:0] m_prev, m_en, m_pend, m_ovr;
  int       m_mode;
  bit       m_irq;
  int       m_id;

  task automatic model_reset();
    m_prev = '0; m_en = '0; m_pend = '0; m_ovr = '0;
    m_mode = ModeIdle; m_irq = 1'b0; m_id = 0;
  endtask

  function automatic int lowest_set(input bit [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_step(input bit r, input bit [3:0] src, input bit we, input bit [1:0] addr,
                            input bit [31:0] wd, input bit claim, input bit comp);
    bit [3:0] rises, en_n, pend_n, ovr_n;
    int       w;
    if (r) begin
      model_reset();
      return;
    end
    rises  = src & ~m_prev;
    en_n   = m_en;
    pend_n = m_pend;
    ovr_n  = m_ovr;
    if (we && addr == 2'd0) en_n = wd[3:0];
    if (we && addr == 2'd1) pend_n = pend_n & ~wd[3:0];
    if (we && addr == 2'd3) ovr_n = ovr_n & ~wd[3:0];
    if (m_mode == ModePresent && claim) pend_n[m_id] = 1'b0;
    pend_n = pend_n | rises;
    ovr_n  = ovr_n | (rises & m_pend);
    case (m_mode)
      ModeIdle: begin
        w = lowest_set(m_pend & m_en);
        if (w >= 0) begin
          m_id = w; m_irq = 1'b1; m_mode = ModePresent;
        end
      end
      ModePresent: begin
        if (claim) begin
          m_irq = 1'b0; m_mode = ModeService;
        end else if (!en_n[m_id] || !pend_n[m_id]) begin
          m_irq = 1'b0; m_mode = ModeIdle;
        end
      end
      default: begin
        if (comp) m_mode = ModeIdle;
      end
    endcase
    m_en = en_n; m_pend = pend_n; m_ovr = ovr_n; m_prev = src;
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] addr);
    case (addr)
      2'd0:    return {28'd0, m_en};
      2'd1:    return {28'd0, m_pend};
      2'd2:    return 32'(m_id);
      default: return {28'd0, m_ovr};
    endcase
  endfunction

  initial begin
    logic [3:0]  r_src;
    logic        r_we, r_claim, r_comp, r_rst;
    logic [1:0]  r_addr, r_rd;
    logic [31:0] r_wd;

    rst = 1'b1; src_irq_i = '0; cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_wdata_i = '0;
    claim_i = 1'b0; complete_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("reset_irq", 32'(irq_o), 32'd0);
    check("reset_id", 32'(irq_id_o), 32'd0);
    for (int a = 0; a < 4; a++) read_check($sformatf("reset_reg%0d", a), 2'(a), 32'd0);

    // src, we, addr, wdata, claim, comp, rd, irq, id, rdata
    // 1: single source handshake
    vecs.push_back(mk(4'h0, 1, 0, 32'h1, 0, 0, 0, 0, 0, 32'h1));
    vecs.push_back(mk(4'h1, 0, 0, 32'h0, 0, 0, 1, 0, 0, 32'h1));
    vecs.push_back(mk(4'h0, 0, 0, 32'h0, 0, 0, 1, 1, 0, 32'h1));
    vecs.push_back(mk(4'h0, 0, 0, 32'h0, 0, 0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(4'h0, 0, 0, 32'h0, 1, 0, 1, 0, 0, 32'h0));
    vecs.push_back(mk(4'h0, 0, 0, 32'h0, 1, 0, 1, 0, 0, 32'h0));
    vecs.push_back(mk(4'h0, 0, 0, 32'h0, 0, 1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(4'h0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h1));
    // 2: simultaneous edges, priority, ENABLE upper bits ignored
    vecs.push_back(mk(4'h0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 32'hF));
    vecs.push_back(mk(4'h6, 0, 0, 32'h0, 0, 0, 1, 0, 0, 32'h6));
    vecs.push_back(mk(4'h6, 0, 0, 32'h0, 0, 0, 2, 1, 1, 32'h1));
    vecs.push_back(mk(4'h0, 0, 0, 32'h0, 0, 1, 1, 1, 1, 32'h6));
    vecs.push_back(mk(4'h0, 0, 0, 32'h0, 1, 0, 1, 0, 1, 32'h4));
    vecs.push_back(mk(4'h0, 0, 0, 32'h0, 0, 0, 1, 0, 1, 32'h4));
    vecs.push_back(mk(4'h0, 0, 0, 32'h0, 0, 1, 1, 0, 1, 32'h4));
    vecs.push_back(mk(4'h0, 0, 0, 32'h0, 0, 0, 2, 1, 2, 32'h2));
    vecs.push_back(mk(4'h0, 0, 0, 32'h0, 1, 0, 1, 0, 2, 32'h0));
    vecs.push_back(mk(4'h0, 0, 0, 32'h0, 0, 1, 1, 0, 2, 32'h0));
    // 3: overrun and its W1C
    vecs.push_back(mk(4'h1, 0, 0, 32'h0, 0, 0, 1, 0, 2, 32'h1));
    vecs.push_back(mk(4'h0, 0, 0, 32'h0, 0, 0, 1, 1, 0, 32'h1));
    vecs.push_back(mk(4'h1, 0, 0, 32'h0, 0, 0, 3, 1, 0, 32'h1));
    vecs.push_back(mk(4'h0, 1, 3, 32'h1, 0, 0, 3, 1, 0, 32'h0));
    vecs.push_back(mk(4'h0, 0, 0, 32'h0, 0, 0, 1, 1, 0, 32'h1));
    vecs.push_back(mk(4'h0, 0, 0, 32'h0, 1, 0, 1, 0, 0, 32'h0));
    vecs.push_back(mk(4'h0, 0, 0, 32'h0, 0, 1, 3, 0, 0, 32'h0));
    // 4: withdraw by disabling, re-enable, no re-arbitration while asserted
    vecs.push_back(mk(4'h8, 0, 0, 32'h0, 0, 0, 1, 0, 0, 32'h8));
    vecs.push_back(mk(4'h0, 0, 0, 32'h0, 0, 0, 1, 1, 3, 32'h8));
    vecs.push_back(mk(4'h0, 1, 0, 32'h7, 0, 0, 0, 0, 3, 32'h7));
    vecs.push_back(mk(4'h0, 0, 0, 32'h0, 0, 0, 1, 0, 3, 32'h8));
    vecs.push_back(mk(4'h0, 1, 0, 32'hF, 0, 0, 0, 0, 3, 32'hF));
    vecs.push_back(mk(4'h0, 0, 0, 32'h0, 0, 0, 2, 1, 3, 32'h3));
    vecs.push_back(mk(4'h2, 0, 0, 32'h0, 0, 0, 1, 1, 3, 32'hA));
    vecs.push_back(mk(4'h0, 0, 0, 32'h0, 1, 0, 1, 0, 3, 32'h2));
    vecs.push_back(mk(4'h0, 0, 0, 32'h0, 0, 1, 1, 0, 3, 32'h2));
    vecs.push_back(mk(4'h0, 0, 0, 32'h0, 0, 0, 2, 1, 1, 32'h1));
    vecs.push_back(mk(4'h0, 0, 0, 32'h0, 1, 0, 1, 0, 1, 32'h0));
    vecs.push_back(mk(4'h0, 0, 0, 32'h0, 0, 1, 1, 0, 1, 32'h0));
    // 5: W1C colliding with a new edge, then edges latch during SERVICE
    vecs.push_back(mk(4'h2, 0, 0, 32'h0, 0, 0, 1, 0, 1, 32'h2));
    vecs.push_back(mk(4'h0, 0, 0, 32'h0, 0, 0, 1, 1, 1, 32'h2));
    vecs.push_back(mk(4'h2, 1, 1, 32'h2, 0, 0, 1, 1, 1, 32'h2));
    vecs.push_back(mk(4'h0, 0, 0, 32'h0, 0, 0, 3, 1, 1, 32'h2));
    vecs.push_back(mk(4'h0, 1, 3, 32'h2, 0, 0, 3, 1, 1, 32'h0));
    vecs.push_back(mk(4'h0, 0, 0, 32'h0, 1, 0, 1, 0, 1, 32'h0));
    vecs.push_back(mk(4'h5, 0, 0, 32'h0, 0, 0, 1, 0, 1, 32'h5));
    vecs.push_back(mk(4'h0, 0, 0, 32'h0, 0, 0, 2, 0, 1, 32'h1));

    foreach (vecs[k]) begin
      drive_cycle(1'b0, vecs[k].src, vecs[k].we, vecs[k].addr, vecs[k].wdata,
                  vecs[k].claim, vecs[k].comp);
      check($sformatf("vec%0d_irq", k), 32'(irq_o), 32'(vecs[k].exp_irq));
      check($sformatf("vec%0d_id", k), 32'(irq_id_o), 32'(vecs[k].exp_id));
      read_check($sformatf("vec%0d_rd%0d", k, vecs[k].rd), vecs[k].rd, vecs[k].exp_rd);
    end

    // 6: reset in SERVICE with PENDING=0x5, claim lost, line high across reset
    drive_cycle(1'b1, 4'h1, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
    check("rst6_irq", 32'(irq_o), 32'd0);
    check("rst6_id", 32'(irq_id_o), 32'd0);
    for (int a = 0; a < 4; a++) read_check($sformatf("rst6_reg%0d", a), 2'(a), 32'd0);
    drive_cycle(1'b0, 4'h1, 1'b0, 2'd0, 32'h0, 1'b1, 1'b1);
    check("rst6_post_irq", 32'(irq_o), 32'd0);
    read_check("rst6_high_edge_pend", 2'd1, 32'h1);
    drive_cycle(1'b0, 4'h1, 1'b1, 2'd0, 32'h1, 1'b0, 1'b0);
    check("rst6_held_irq", 32'(irq_o), 32'd0);
    drive_cycle(1'b0, 4'h1, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    check("rst6_present_irq", 32'(irq_o), 32'd1);
    check("rst6_present_id", 32'(irq_id_o), 32'd0);
    read_check("rst6_no_ovr_level", 2'd3, 32'h0);

    // Randomised run against the reference model
    drive_cycle(1'b1, 4'h0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    model_reset();
    r_src = '0;
    for (int c = 0; c < 3000; c++) begin
      r_rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 2) == 0) r_src = 4'($urandom);
      r_we   = ($urandom_range(0, 9) == 0);
      r_addr = 2'($urandom);
      r_wd   = $urandom;
      if (r_addr == 2'd0 && $urandom_range(0, 1) == 0) r_wd = 32'hF;
      r_claim = ($urandom_range(0, 3) == 0);
      r_comp  = ($urandom_range(0, 3) == 0);
      r_rd    = 2'($urandom);
      drive_cycle(r_rst, r_src, r_we, r_addr, r_wd, r_claim, r_comp);
      model_step(r_rst, r_src, r_we, r_addr, r_wd, r_claim, r_comp);
      check($sformatf("rand%0d_irq", c), 32'(irq_o), 32'(m_irq));
      check($sformatf("rand%0d_id", c), 32'(irq_id_o), 32'(m_id));
      read_check($sformatf("rand%0d_rd%0d", c, r_rd), r_rd, model_read(r_rd));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
